dht11_poll_ctrl: RTL and testbench

Sequencing controller for the DHT11 reader in the cold-storage monitor. It gates the reader's `en` input to take one measurement per sample period and bounds each attempt with a timeout. Failed or timed-out reads are retried a fixed number of times before a fault is flagged. Every validated reading is latched, published with a one-cycle valid strobe, and checked against high and low temperature limits.

---
 rtl/dht11_poll_ctrl.sv | 143 ++++++++++++++
 tb/tb_dht11_poll_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dht11_poll_ctrl.sv
// dht11_poll_ctrl: sequences a DHT11 reader. One read per sample period,
// each attempt bounded by a timeout, failed attempts retried after a gap,
// fault raised after MAX_RETRY consecutive failures. Valid readings are
// latched, strobed and compared against temperature limits.
//
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   run            : level, 1 = poll continuously
//   sensor_en      : reader enable (high exactly while reading)
//   sensor_ready   : reader data_ready pulse
//   sensor_hum/temp: reader data
//   humidity/temperature : last valid reading
//   valid          : 1-cycle strobe on update
//   alarm_hi/lo    : last temperature above TEMP_HI / below TEMP_LO
//   fault          : MAX_RETRY consecutive failed attempts
//   err_count      : total failed attempts, saturating
module dht11_poll_ctrl #(
  parameter int unsigned SAMPLE_PERIOD = 20_000_000,
  parameter int unsigned READ_TIMEOUT  = 300_000,
  parameter int unsigned RETRY_GAP     = 10_000_000,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned TEMP_HI       = 8,
  parameter int unsigned TEMP_LO       = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic       sensor_en,
  input  logic       sensor_ready,
  input  logic [7:0] sensor_hum,
  input  logic [7:0] sensor_temp,
  output logic [7:0] humidity,
  output logic [7:0] temperature,
  output logic       valid,
  output logic       alarm_hi,
  output logic       alarm_lo,
  output logic       fault,
  output logic [7:0] err_count
);

  localparam int unsigned TMR_W = 32;
  localparam int unsigned RTY_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_GAP,
    ST_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [RTY_W-1:0]   retry_q, retry_d, retry_inc;
  logic               sensor_en_d;
  logic [7:0]         humidity_d, temperature_d, err_count_d;
  logic               valid_d, alarm_hi_d, alarm_lo_d, fault_d;

  // Next-state, timer, counters and registered output values.
  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q + TMR_W'(1);
    retry_d       = retry_q;
    retry_inc     = retry_q + RTY_W'(1);
    humidity_d    = humidity;
    temperature_d = temperature;
    valid_d       = 1'b0;
    alarm_hi_d    = alarm_hi;
    alarm_lo_d    = alarm_lo;
    fault_d       = fault;
    err_count_d   = err_count;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_READ;
      end
      ST_READ: begin
        // A ready pulse wins over a coincident timeout or run drop.
        if (sensor_ready) begin
          humidity_d    = sensor_hum;
          temperature_d = sensor_temp;
          valid_d       = 1'b1;
          alarm_hi_d    = (sensor_temp > 8'(TEMP_HI));
          alarm_lo_d    = (sensor_temp < 8'(TEMP_LO));
          retry_d       = '0;
          fault_d       = 1'b0;
          state_d       = ST_WAIT;
        end else if (run && (timer_q == TMR_W'(READ_TIMEOUT - 1))) begin
          if (err_count != 8'hFF) err_count_d = err_count + 8'd1;
          if (retry_inc == RTY_W'(MAX_RETRY)) begin
            fault_d = 1'b1;
            retry_d = '0;
            state_d = ST_WAIT;
          end else begin
            retry_d = retry_inc;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (timer_q == TMR_W'(RETRY_GAP - 1)) state_d = ST_READ;
      end
      ST_WAIT: begin
        if (timer_q == TMR_W'(SAMPLE_PERIOD - 1)) state_d = ST_READ;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!run) state_d = ST_IDLE;
    if ((state_d != state_q) || (state_q == ST_IDLE)) timer_d = '0;

    sensor_en_d = (state_d == ST_READ);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      retry_q     <= '0;
      sensor_en   <= 1'b0;
      humidity    <= '0;
      temperature <= '0;
      valid       <= 1'b0;
      alarm_hi    <= 1'b0;
      alarm_lo    <= 1'b0;
      fault       <= 1'b0;
      err_count   <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      sensor_en   <= sensor_en_d;
      humidity    <= humidity_d;
      temperature <= temperature_d;
      valid       <= valid_d;
      alarm_hi    <= alarm_hi_d;
      alarm_lo    <= alarm_lo_d;
      fault       <= fault_d;
      err_count   <= err_count_d;
    end
  end

endmodule

// File: tb/tb_dht11_poll_ctrl.sv
// Self-checking bench for dht11_poll_ctrl with short timing parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dht11_poll_ctrl;

  localparam int unsigned SP  = 100;
  localparam int unsigned TO  = 50;
  localparam int unsigned GAP = 10;
  localparam int unsigned MR  = 3;
  localparam int unsigned THI = 8;
  localparam int unsigned TLO = 2;
  localparam int          BOUND = 2000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       sensor_en;
  logic       sensor_ready;
  logic [7:0] sensor_hum;
  logic [7:0] sensor_temp;
  logic [7:0] humidity;
  logic [7:0] temperature;
  logic       valid;
  logic       alarm_hi;
  logic       alarm_lo;
  logic       fault;
  logic [7:0] err_count;

  int checks   = 0;
  int failures = 0;

  // Reference model of the architecturally visible state.
  int m_hum, m_temp, m_err, m_retry;
  bit m_fault;

  always #5 clk = ~clk;

  dht11_poll_ctrl #(
    .SAMPLE_PERIOD(SP),
    .READ_TIMEOUT (TO),
    .RETRY_GAP    (GAP),
    .MAX_RETRY    (MR),
    .TEMP_HI      (THI),
    .TEMP_LO      (TLO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .sensor_en   (sensor_en),
    .sensor_ready(sensor_ready),
    .sensor_hum  (sensor_hum),
    .sensor_temp (sensor_temp),
    .humidity    (humidity),
    .temperature (temperature),
    .valid       (valid),
    .alarm_hi    (alarm_hi),
    .alarm_lo    (alarm_lo),
    .fault       (fault),
    .err_count   (err_count)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"},    32'(sensor_en),   0);
    chk({tag, "_hum"},   32'(humidity),    0);
    chk({tag, "_temp"},  32'(temperature), 0);
    chk({tag, "_valid"}, 32'(valid),       0);
    chk({tag, "_ahi"},   32'(alarm_hi),    0);
    chk({tag, "_alo"},   32'(alarm_lo),    0);
    chk({tag, "_fault"}, 32'(fault),       0);
    chk({tag, "_err"},   32'(err_count),   0);
  endtask

  // Counts consecutive cycles with sensor_en low; ends on the first high cycle.
  task automatic count_low(output int n);
    n = 0;
    while (sensor_en !== 1'b1 && n < BOUND) begin
      n++;
      tick();
    end
  endtask

  // Counts consecutive cycles with sensor_en high; ends on the first low cycle.
  task automatic count_high(output int n);
    n = 0;
    while (sensor_en === 1'b1 && n < BOUND) begin
      n++;
      tick();
    end
  endtask

  // Entered on the first READ cycle; reader answers d cycles later.
  task automatic read_good(input int d, input logic [7:0] h, input logic [7:0] t);
    repeat (d) tick();
    chk("en_in_read", 32'(sensor_en), 1);
    sensor_ready = 1'b1;
    sensor_hum   = h;
    sensor_temp  = t;
    tick();
    sensor_ready = 1'b0;
    sensor_hum   = 8'($urandom);
    sensor_temp  = 8'($urandom);
    m_hum   = int'(h);
    m_temp  = int'(t);
    m_fault = 1'b0;
    m_retry = 0;
    chk("valid_hi",  32'(valid),       1);
    chk("hum",       32'(humidity),    32'(m_hum));
    chk("temp",      32'(temperature), 32'(m_temp));
    chk("alarm_hi",  32'(alarm_hi),    32'(m_temp > int'(THI)));
    chk("alarm_lo",  32'(alarm_lo),    32'(m_temp < int'(TLO)));
    chk("fault_clr", 32'(fault),       0);
    chk("err_keep",  32'(err_count),   32'(m_err));
    chk("en_drop",   32'(sensor_en),   0);
  endtask

  // Valid is a single cycle and WAIT lasts a full sample period.
  task automatic after_read();
    int n;
    tick();
    chk("valid_lo", 32'(valid), 0);
    count_low(n);
    chk("wait_len", 32'(n + 1), SP);
  endtask

  // One unanswered attempt starting on the first READ cycle.
  task automatic do_timeout();
    int n;
    count_high(n);
    chk("read_len", 32'(n), TO);
    if (m_err < 255) m_err++;
    m_retry++;
    if (m_retry == int'(MR)) begin
      m_fault = 1'b1;
      m_retry = 0;
    end
    chk("to_err",   32'(err_count), 32'(m_err));
    chk("to_fault", 32'(fault),     32'(m_fault));
    count_low(n);
    chk("off_len", 32'(n), (m_retry == 0) ? SP : GAP);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; run = 1'b1; sensor_ready = 1'b0;
    sensor_hum = '0; sensor_temp = '0;
    m_hum = 0; m_temp = 0; m_err = 0; m_retry = 0; m_fault = 1'b0;

    // Reset with run held high.
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    count_low(n);
    chk("first_read_now", 32'(n), 1);

    // Basic read, one-cycle valid, 100-cycle wait.
    read_good(20, 8'd45, 8'd5);
    after_read();

    // sensor_ready during WAIT is ignored.
    read_good(20, 8'd46, 8'd6);
    tick();
    chk("valid_lo2", 32'(valid), 0);
    repeat (4) tick();
    sensor_ready = 1'b1; sensor_hum = 8'd99; sensor_temp = 8'd99;
    tick();
    sensor_ready = 1'b0;
    chk("ign_valid", 32'(valid),    0);
    chk("ign_hum",   32'(humidity), 32'(m_hum));
    count_low(n);
    chk("ign_wait_rest", 32'(n), SP - 6);

    // High then low alarm.
    read_good(20, 8'd50, 8'd9);
    after_read();
    read_good(20, 8'd50, 8'd1);
    after_read();

    // Randomized good reads.
    for (int k = 0; k < 6; k++) begin
      read_good(int'($urandom_range(0, TO - 1)), 8'($urandom_range(0, 99)),
                8'($urandom_range(0, 15)));
      after_read();
    end

    // Three timeouts raise fault, then a good read clears it.
    for (int k = 0; k < 3; k++) do_timeout();
    read_good(20, 8'd40, 8'd4);
    after_read();

    // Ready coincident with the timeout cycle.
    read_good(int'(TO) - 1, 8'd33, 8'd3);
    after_read();

    // Drop run mid-READ, then re-raise.
    repeat (25) tick();
    run = 1'b0;
    tick();
    chk("stop_en",    32'(sensor_en), 0);
    chk("stop_valid", 32'(valid),     0);
    chk("stop_hum",   32'(humidity),  32'(m_hum));
    repeat (5) tick();
    chk("idle_en", 32'(sensor_en), 0);
    run = 1'b1;
    tick();
    chk("restart_en", 32'(sensor_en), 1);

    // Timeout into GAP, then asynchronous reset mid-GAP.
    count_high(n);
    chk("read_len2", 32'(n), TO);
    m_err++;
    chk("gap_err", 32'(err_count), 32'(m_err));
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    m_hum = 0; m_temp = 0; m_err = 0; m_retry = 0; m_fault = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Saturation of err_count.
    count_low(n);
    for (int k = 0; k < 260; k++) do_timeout();
    chk("err_sat", 32'(err_count), 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
